// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per cycle, signed or unsigned,
// with a divide-by-zero fast path and sign fix-up in a final cycle.
module divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   RA,
  input  logic [WIDTH-1:0]   RB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] RZ,
  output logic               div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [CW-1:0]    cnt;
  logic             q_neg, r_neg, dz;

  logic             a_neg, b_neg, rb_zero;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0]   trial;

  always_comb begin
    a_neg   = signed_op & RA[WIDTH-1];
    b_neg   = signed_op & RB[WIDTH-1];
    a_mag   = a_neg ? -RA : RA;
    b_mag   = b_neg ? -RB : RB;
    rb_zero = (RB == '0);
    // rem < dvs always holds, so {rem, next bit} fits in WIDTH+1 bits and
    // the top bit of the difference is a reliable sign.
    trial   = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    q_fix   = q_neg ? -quo : quo;
    r_fix   = r_neg ? -rem : rem;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = rb_zero ? FIX : CALC;
      CALC:    if (cnt == CW'(1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      RZ          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_nx != IDLE);
      case (state)
        IDLE: if (start) begin
          dz    <= rb_zero;
          dvs   <= b_mag;
          rem   <= '0;
          // divide-by-zero reports the raw dividend, so keep it unmodified
          quo   <= rb_zero ? RA : a_mag;
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          cnt   <= rb_zero ? '0 : CW'(WIDTH);
        end
        CALC: begin
          if (!trial[WIDTH]) rem <= trial[WIDTH-1:0];
          else               rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dz;
          RZ          <= dz ? {quo, {WIDTH{1'b1}}} : {r_fix, q_fix};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: driver pushes expected results, monitor
// pops on done and checks value, flag, latency, busy and output hold.
module tb_divider_seq;
  logic        clock = 0, reset = 1, start = 0, signed_op = 0;
  logic [31:0] RA = 0, RB = 0;
  logic        busy, done, div_by_zero;
  logic [63:0] RZ;

  divider_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .signed_op(signed_op),
    .RA(RA), .RB(RB), .busy(busy), .done(done), .RZ(RZ),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] rz;
    logic        dz;
    int          acc;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0, checks = 0, cyc = 0;
  bit          skip_busy = 0;
  logic [63:0] last_rz = '0;
  logic        last_dz = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sbv, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
    end else begin
      sa  = longint'({32'd0, a});
      sbv = longint'({32'd0, b});
    end
    q = sa / sbv;
    r = sa % sbv;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor
  always @(posedge clock) begin
    logic rst_s;
    exp_t e;
    logic exp_busy;
    rst_s = reset;
    cyc++;
    #1;
    if (rst_s) begin
      last_rz = '0;
      last_dz = 1'b0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rz", RZ, e.rz);
          chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
          chk("done_latency", 64'(cyc), 64'(e.due));
          last_rz = e.rz;
          last_dz = e.dz;
        end
      end else begin
        chk("rz_hold", RZ, last_rz);
        chk("dz_hold", {63'd0, div_by_zero}, {63'd0, last_dz});
      end
      if (!skip_busy) begin
        exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].due);
        chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      end
    end
  end

  // Drive a request at the current negedge; accepted at the next posedge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit push, input logic [63:0] exp_rz);
    exp_t e;
    RA = a; RB = b; signed_op = s; start = 1;
    if (push) begin
      e.rz  = exp_rz;
      e.dz  = (b == 32'd0);
      e.acc = cyc + 1;
      e.due = cyc + 1 + ((b == 32'd0) ? 1 : 33);
      sb.push_back(e);
    end
    @(negedge clock);
    start = 0;
    RA = $urandom; RB = $urandom; signed_op = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      chk("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    wait_idle();
    drive(a, b, s, 1, ref_div(a, b, s));
  endtask

  task automatic issue_k(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] k);
    wait_idle();
    drive(a, b, s, 1, k);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          sel;

    repeat (3) @(negedge clock);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_rz", RZ, 64'd0);
    chk("rst_dz", {63'd0, div_by_zero}, 64'd0);
    reset = 0;

    // Known-answer vectors
    issue_k(32'd100, 32'd7, 0, 64'h00000002_0000000E);
    issue_k(-32'sd100, 32'd7, 1, 64'hFFFFFFFE_FFFFFFF2);
    issue_k(32'd100, -32'sd7, 1, 64'h00000002_FFFFFFF2);
    issue_k(32'h80000000, 32'hFFFFFFFF, 1, 64'h00000000_80000000);
    issue_k(32'h80000000, 32'hFFFFFFFF, 0, 64'h80000000_00000000);
    issue_k(32'd5, 32'd0, 0, 64'h00000005_FFFFFFFF);
    issue_k(32'd9, 32'd3, 0, 64'h00000000_00000003);
    issue_k(32'd5, 32'd0, 1, 64'h00000005_FFFFFFFF);
    issue_k(32'hFFFFFFF6, 32'd0, 1, 64'hFFFFFFF6_FFFFFFFF);

    // start during busy with other operands must be ignored
    issue(32'd1000, 32'd33, 0);
    repeat (4) @(negedge clock);
    drive(32'd77, 32'd0, 1, 0, 64'd0);

    // reset mid-operation aborts; start right after reset is accepted
    wait_idle();
    skip_busy = 1;
    drive(32'd100, 32'd7, 0, 0, 64'd0);
    repeat (9) @(negedge clock);
    reset = 1;
    @(negedge clock);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_rz", RZ, 64'd0);
    chk("abort_dz", {63'd0, div_by_zero}, 64'd0);
    reset = 0;
    skip_busy = 0;
    drive(32'd12345, 32'd10, 0, 1, ref_div(32'd12345, 32'd10, 0));

    // Randomized, back-to-back on the done cycle
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      s   = 1'($urandom);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: b = b >> $urandom_range(1, 30);
        4: b = 32'(-$urandom_range(1, 1000));
        default: ;
      endcase
      issue(a, b, s);
    end

    wait_idle();
    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
